ram_cycle_ctrl: RTL

//  Bus-cycle sequencer that consumes the decoder's ramce/OVR selects and runs the 68000 handshake.

---
 rtl/ram_cycle_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ram_cycle_ctrl.sv
// ram_cycle_ctrl
//   Bus-cycle sequencer for the A500 IDE-RAM CPLD. It takes the decoder's
//   ramce/ctrl_sel selects and runs the 68000 asynchronous bus handshake.
//   It drives the SRAM strobes, the data-buffer enable and DTACK.
//   Control-register cycles are acknowledged without any SRAM strobes.
//
// Parameters
//   WAIT_STATES : extra CLK cycles between strobe assertion and DTACK (0..7)
//   CNT_W       : width of the wait counter, must be able to hold WAIT_STATES
//
// Ports
//   CLK      in  : 68000 CPU clock, rising-edge active
//   _RST     in  : asynchronous active-low reset
//   _AS      in  : CPU address strobe, active-low
//   _UDS     in  : upper data strobe, active-low
//   _LDS     in  : lower data strobe, active-low
//   RW       in  : 1 = read, 0 = write
//   ramce    in  : decoder select for the RAM/maprom range
//   ctrl_sel in  : decoder select for the control register
//   ram_oe_n out : SRAM output enable, active-low
//   ram_we_n out : SRAM write enable, active-low
//   ram_ub_n out : SRAM upper byte enable, active-low
//   ram_lb_n out : SRAM lower byte enable, active-low
//   buf_oe_n out : data buffer enable, active-low
//   dtack_n  out : DTACK to the CPU, active-low
//   dtack_oe out : drive enable for dtack_n (pin is tristated when 0)
module ram_cycle_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 3
) (
    input  logic CLK,
    input  logic _RST,
    input  logic _AS,
    input  logic _UDS,
    input  logic _LDS,
    input  logic RW,
    input  logic ramce,
    input  logic ctrl_sel,
    output logic ram_oe_n,
    output logic ram_we_n,
    output logic ram_ub_n,
    output logic ram_lb_n,
    output logic buf_oe_n,
    output logic dtack_n,
    output logic dtack_oe
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_STATES);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_as_n;
    logic             r_uds_n;
    logic             r_lds_n;
    logic             r_ramce;
    logic             r_ctrl;
    logic             r_is_ram;
    logic             r_rw_l;

    logic w_ds;
    logic w_go;
    logic w_active;
    logic w_ram_active;

    // A write only makes progress once the CPU has put a data strobe out;
    // a read makes progress on every clock.
    assign w_ds = ~r_uds_n | ~r_lds_n;
    assign w_go = r_rw_l | w_ds;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_as_n   <= 1'b1;
            r_uds_n  <= 1'b1;
            r_lds_n  <= 1'b1;
            r_ramce  <= 1'b0;
            r_ctrl   <= 1'b0;
            r_is_ram <= 1'b0;
            r_rw_l   <= 1'b1;
        end else begin
            // Single synchronising stage for the asynchronous CPU strobes.
            r_as_n  <= _AS;
            r_uds_n <= _UDS;
            r_lds_n <= _LDS;
            r_ramce <= ramce;
            r_ctrl  <= ctrl_sel;

            case (r_state)
                S_IDLE: begin
                    // ramce takes priority when both selects are active.
                    if (!r_as_n && r_ramce) begin
                        r_state  <= S_ACCESS;
                        r_cnt    <= LP_WAIT;
                        r_is_ram <= 1'b1;
                        r_rw_l   <= RW;
                    end else if (!r_as_n && r_ctrl) begin
                        r_state  <= S_ACCESS;
                        r_cnt    <= '0;
                        r_is_ram <= 1'b0;
                        r_rw_l   <= RW;
                    end
                end
                S_ACCESS: begin
                    // _AS released early means the cycle was ended elsewhere
                    // (bus error or another DTACK source): abandon it.
                    if (r_as_n) begin
                        r_state <= S_RECOVER;
                    end else if (w_go) begin
                        if (r_cnt == '0) begin
                            r_state <= S_ACK;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    if (r_as_n) begin
                        r_state <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_active     = (r_state == S_ACCESS) || (r_state == S_ACK);
    assign w_ram_active = w_active && r_is_ram;

    assign ram_oe_n = ~(w_ram_active & r_rw_l);
    assign ram_we_n = ~(w_ram_active & ~r_rw_l & w_ds);
    assign ram_ub_n = w_ram_active ? r_uds_n : 1'b1;
    assign ram_lb_n = w_ram_active ? r_lds_n : 1'b1;
    assign buf_oe_n = ~w_ram_active;
    assign dtack_n  = ~(r_state == S_ACK);
    // RECOVER keeps the pin driven so DTACK is actively pulled high once
    // before it is released to the external pull-up.
    assign dtack_oe = (r_state != S_IDLE);

endmodule
